// File: rtl/anim_sprite_blob.sv
// Animated, mirrorable, scalable sprite renderer with a 3-cycle pipeline.
// It drives an external image ROM and an external palette ROM, each with a 1-cycle read latency.
module anim_sprite_blob #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned HEIGHT          = 32,
  parameter int unsigned NUM_DIRS        = 4,
  parameter int unsigned NUM_FRAMES      = 4,
  parameter int unsigned FRAME_TICKS     = 8,
  parameter int unsigned SCALE_LOG2      = 0,
  parameter logic [7:0]  TRANSPARENT_IDX = 8'h00,
  parameter logic [11:0] BG_COLOR        = 12'hFFF,
  parameter int unsigned ADDR_W          = $clog2(NUM_DIRS*NUM_FRAMES*WIDTH*HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              frame_start_in,
  input  logic [1:0]        dir_in,
  input  logic              walking_in,
  input  logic              mirror_in,
  output logic [ADDR_W-1:0] image_addr_out,
  input  logic [7:0]        image_bits_in,
  output logic [7:0]        palette_addr_out,
  input  logic [11:0]       palette_rgb_in,
  output logic [11:0]       pixel_out,
  output logic              opaque_out
);
  localparam int unsigned DW = (NUM_DIRS > 1)    ? $clog2(NUM_DIRS)    : 1;
  localparam int unsigned FW = (NUM_FRAMES > 1)  ? $clog2(NUM_FRAMES)  : 1;
  localparam int unsigned TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned CW = (WIDTH > 1)       ? $clog2(WIDTH)       : 1;
  localparam int unsigned RW = (HEIGHT > 1)      ? $clog2(HEIGHT)      : 1;
  localparam logic [11:0] BOX_W = 12'(WIDTH << SCALE_LOG2);
  localparam logic [11:0] BOX_H = 12'(HEIGHT << SCALE_LOG2);

  typedef enum logic {IDLE, WALK} state_t;

  state_t            state;
  logic [FW-1:0]     anim_frame;
  logic [TW-1:0]     tick_cnt;
  logic [DW-1:0]     dir_q;
  logic [DW-1:0]     dir_sel;
  logic              mirror_q;

  logic [11:0]       hc, vc, xs, ys, dx, dy;
  logic              hit;
  logic [CW-1:0]     col_raw, col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] addr_next;
  logic              v1, v2, v3, t3;

  assign dir_sel = (32'(dir_in) >= NUM_DIRS) ? '0 : DW'(dir_in);

  // Shadow registers and the animation FSM only move on frame_start, so a frame never tears
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      anim_frame <= '0;
      tick_cnt   <= '0;
      dir_q      <= '0;
      mirror_q   <= 1'b0;
    end else if (frame_start_in) begin
      dir_q    <= dir_sel;
      mirror_q <= mirror_in;
      case (state)
        IDLE: begin
          anim_frame <= '0;
          tick_cnt   <= '0;
          if (walking_in) state <= WALK;
        end
        WALK: begin
          if (!walking_in) begin
            state      <= IDLE;
            anim_frame <= '0;
            tick_cnt   <= '0;
          end else if (32'(tick_cnt) == FRAME_TICKS - 1) begin
            tick_cnt   <= '0;
            anim_frame <= (32'(anim_frame) == NUM_FRAMES - 1) ? '0 : anim_frame + FW'(1);
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 12-bit widening keeps x_in + box size from wrapping near the right screen edge
  assign hc  = {1'b0, hcount_in};
  assign vc  = {2'b0, vcount_in};
  assign xs  = {1'b0, x_in};
  assign ys  = {2'b0, y_in};
  assign dx  = hc - xs;
  assign dy  = vc - ys;
  assign hit = (hc >= xs) && (hc < xs + BOX_W) && (vc >= ys) && (vc < ys + BOX_H);

  assign col_raw = CW'(dx >> SCALE_LOG2);
  assign col     = mirror_q ? (CW'(WIDTH - 1) - col_raw) : col_raw;
  assign row     = RW'(dy >> SCALE_LOG2);

  assign addr_next = hit ? ADDR_W'((32'(dir_q) * NUM_FRAMES + 32'(anim_frame)) * WIDTH * HEIGHT
                                   + 32'(row) * WIDTH + 32'(col))
                         : '0;

  assign palette_addr_out = image_bits_in;

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      image_addr_out <= '0;
      v1             <= 1'b0;
      v2             <= 1'b0;
      v3             <= 1'b0;
      t3             <= 1'b0;
      pixel_out      <= BG_COLOR;
      opaque_out     <= 1'b0;
    end else begin
      image_addr_out <= addr_next;
      v1             <= hit;
      v2             <= v1;
      v3             <= v2;
      t3             <= (image_bits_in == TRANSPARENT_IDX);
      if (v3 && !t3) begin
        pixel_out  <= palette_rgb_in;
        opaque_out <= 1'b1;
      end else begin
        pixel_out  <= BG_COLOR;
        opaque_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_anim_sprite_blob.sv
// Bench for anim_sprite_blob at scale 1x and 2x, with behavioural image and palette ROMs.
// It runs directed checks first, then random traffic compared against a reference model.
module tb_anim_sprite_blob;
  localparam logic [12:0] BG13 = 13'h0FFF;

  logic        clk;
  logic        rst;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        fs;
  logic [1:0]  dir;
  logic        walking;
  logic        mirror;

  logic [13:0] addr0, addr1;
  logic [7:0]  img_d0, img_d1, paddr0, paddr1;
  logic [11:0] pal_d0, pal_d1, pix0, pix1;
  logic        op0, op1;

  logic [7:0]  img [0:16383];
  logic [11:0] pal [0:255];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_walk;
  int          m_pulses;
  int          m_dir;
  bit          m_mirror;
  logic [12:0] q0[$], q1[$];

  anim_sprite_blob #(.SCALE_LOG2(0)) dut0 (
    .pixel_clk_in(clk), .rst_in(rst), .x_in(x_pos), .y_in(y_pos),
    .hcount_in(hcount), .vcount_in(vcount), .frame_start_in(fs), .dir_in(dir),
    .walking_in(walking), .mirror_in(mirror), .image_addr_out(addr0),
    .image_bits_in(img_d0), .palette_addr_out(paddr0), .palette_rgb_in(pal_d0),
    .pixel_out(pix0), .opaque_out(op0));

  anim_sprite_blob #(.SCALE_LOG2(1)) dut1 (
    .pixel_clk_in(clk), .rst_in(rst), .x_in(x_pos), .y_in(y_pos),
    .hcount_in(hcount), .vcount_in(vcount), .frame_start_in(fs), .dir_in(dir),
    .walking_in(walking), .mirror_in(mirror), .image_addr_out(addr1),
    .image_bits_in(img_d1), .palette_addr_out(paddr1), .palette_rgb_in(pal_d1),
    .pixel_out(pix1), .opaque_out(op1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    img_d0 <= img[addr0];
    img_d1 <= img[addr1];
    pal_d0 <= pal[paddr0];
    pal_d1 <= pal[paddr1];
  end

  function automatic void model_expect(input int s, output int addr, output logic [12:0] po);
    int hc, vc, x, y, col, row, frame, idx;
    bit hit;
    hc = int'(hcount); vc = int'(vcount); x = int'(x_pos); y = int'(y_pos);
    hit = (hc >= x) && (hc < x + (32 << s)) && (vc >= y) && (vc < y + (32 << s));
    frame = m_walk ? (m_pulses / 8) % 4 : 0;
    addr = 0;
    po = BG13;
    if (hit) begin
      col = (hc - x) >> s;
      if (m_mirror) col = 31 - col;
      row = (vc - y) >> s;
      addr = (m_dir * 4 + frame) * 1024 + row * 32 + col;
      idx = int'(img[addr]);
      po = (idx == 0) ? BG13 : {1'b1, pal[idx]};
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int a0, a1, ea0, ea1;
    logic [12:0] e0, e1, ep0, ep1;
    model_expect(0, a0, e0);
    model_expect(1, a1, e1);
    @(posedge clk);
    if (rst) begin
      m_walk = 0; m_pulses = 0; m_dir = 0; m_mirror = 0;
      q0 = '{BG13, BG13, BG13};
      q1 = '{BG13, BG13, BG13};
      ea0 = 0; ea1 = 0; ep0 = BG13; ep1 = BG13;
    end else begin
      if (fs) begin
        m_dir = int'(dir);
        m_mirror = mirror;
        if (!m_walk) begin
          m_walk = walking;
          m_pulses = 0;
        end else if (walking) begin
          m_pulses++;
        end else begin
          m_walk = 0;
          m_pulses = 0;
        end
      end
      q0.push_back(e0);
      q1.push_back(e1);
      ep0 = q0.pop_front();
      ep1 = q1.pop_front();
      ea0 = a0; ea1 = a1;
    end
    #1;
    check("addr_s0", 32'(addr0), 32'(ea0));
    check("addr_s1", 32'(addr1), 32'(ea1));
    check("pix_s0", 32'({op0, pix0}), 32'(ep0));
    check("pix_s1", 32'({op1, pix1}), 32'(ep1));
  endtask

  task automatic px(input int h, input int v);
    hcount = 11'(h);
    vcount = 10'(v);
    tick();
  endtask

  task automatic pulses(input int n);
    fs = 1'b1;
    for (int i = 0; i < n; i++) tick();
    fs = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++)
      img[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int i = 0; i < 256; i++) pal[i] = 12'($urandom);
    img[4163] = 8'd5;
    pal[5]    = 12'h3A7;
    img[4164] = 8'd0;

    x_pos = 11'd100; y_pos = 10'd50; hcount = 11'd103; vcount = 10'd52;
    dir = 2'd1; mirror = 1'b0; walking = 1'b0; fs = 1'b0; rst = 1'b1;

    // reset with the beam inside the sprite
    tick();
    check("rst_addr", 32'(addr0), 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("post_rst_pix", 32'({op0, pix0}), 32'(BG13));

    // latch dir=1, then exact-latency probe
    pulses(1);
    px(0, 0); px(0, 0); px(0, 0);
    px(103, 52);
    check("lat_addr_s0", 32'(addr0), 32'd4163);
    check("lat_addr_s1", 32'(addr1), 32'd4129);
    px(0, 0); px(0, 0);
    check("lat_early", 32'({op0, pix0}), 32'(BG13));
    px(0, 0);
    check("lat_pix", 32'({op0, pix0}), 32'h13A7);

    // transparent index
    px(104, 52); px(0, 0); px(0, 0); px(0, 0);
    check("transp", 32'({op0, pix0}), 32'(BG13));

    // box edges
    px(99, 52);  check("left_out", 32'(addr0), 32'd0);
    px(100, 52); check("left_in", 32'(addr0), 32'd4160);
    px(131, 52); check("right_in", 32'(addr0), 32'd4191);
    px(132, 52); check("right_out", 32'(addr0), 32'd0);
    check("s1_wide", 32'(addr1), 32'd4144);
    px(163, 52); check("s1_edge", 32'(addr1), 32'd4159);
    px(164, 52); check("s1_out", 32'(addr1), 32'd0);

    // right screen edge: no wraparound
    x_pos = 11'd2040;
    px(2047, 52); check("edge_hit", 32'(addr0), 32'd4167);
    px(5, 52);    check("edge_nowrap", 32'(addr0), 32'd0);
    x_pos = 11'd100;

    // mirror
    mirror = 1'b1; pulses(1);
    px(100, 52); check("mirror", 32'(addr0), 32'd4191);
    mirror = 1'b0; pulses(1);

    // direction change only takes effect at frame_start
    dir = 2'd3;
    px(100, 52); check("dir_hold", 32'(addr0), 32'd4160);
    pulses(1);
    px(100, 52); check("dir_new", 32'(addr0), 32'd12352);

    // animation with the beam on row 0, col 0
    dir = 2'd1; walking = 1'b1;
    hcount = 11'd100; vcount = 10'd50;
    pulses(1);
    pulses(8);
    tick(); check("anim_f1", 32'(addr0), 32'd5120);
    pulses(23);
    tick(); check("anim_f3", 32'(addr0), 32'd7168);
    pulses(1);
    tick(); check("anim_wrap", 32'(addr0), 32'd4096);
    pulses(10);
    walking = 1'b0;
    pulses(1);
    tick(); check("anim_stop", 32'(addr0), 32'd4096);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      fs = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) walking = ~walking;
      dir = 2'($urandom);
      mirror = 1'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 2))
          0: x_pos = 11'd100;
          1: x_pos = 11'd2040;
          default: x_pos = 11'($urandom);
        endcase
        y_pos = 10'($urandom_range(0, 1023));
      end
      hcount = 11'(int'(x_pos) + int'($urandom_range(0, 140)) - 6);
      vcount = 10'(int'(y_pos) + int'($urandom_range(0, 70)) - 3);
      tick();
    end
    rst = 1'b0; fs = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/anim_sprite_blob.md
Name: anim_sprite_blob

Overview:
- Parametrised successor to the single-frame directional player sprite.
- Renders one WIDTHxHEIGHT sprite at integer scale with:
  - per-direction multi-frame walk animation;
  - optional horizontal mirroring;
  - transparent colour index;
  - fixed, documented pipeline latency.
- Sits in the per-player render path between the VGA timing generator and the layer compositor.
- Drives one external synchronous image ROM and one external palette ROM, each with 1-cycle read latency.

Parameters:
- WIDTH, 32, sprite width in source pixels.
- HEIGHT, 32, sprite height in source pixels.
- NUM_DIRS, 4, direction count; dir_in values >= NUM_DIRS are treated as 0.
- NUM_FRAMES, 4, animation frames per direction.
- FRAME_TICKS, 8, frame_start_in pulses per animation step (>=1).
- SCALE_LOG2, 0, on-screen magnification is 2^SCALE_LOG2 (0..2).
- TRANSPARENT_IDX, 8'h00, image index treated as see-through.
- BG_COLOR, 12'hFFF, pixel_out value when not opaque.
- ADDR_W, $clog2(NUM_DIRS*NUM_FRAMES*WIDTH*HEIGHT), image ROM address width (14 at defaults).

Ports:
- pixel_clk_in  in  1  pixel clock; all logic is on its rising edge.
- rst_in  in  1  synchronous, active-high reset.
- x_in  in  11  sprite left edge (screen pixels).
- y_in  in  10  sprite top edge.
- hcount_in  in  11  current pixel column.
- vcount_in  in  10  current pixel row.
- frame_start_in  in  1  one-cycle pulse at start of each video frame.
- dir_in  in  2  requested direction (0=L,1=R,2=U,3=D).
- walking_in  in  1  1 = animate, 0 = stand.
- mirror_in  in  1  1 = flip sprite horizontally.
- image_addr_out  out  ADDR_W  image ROM address, registered.
- image_bits_in  in  8  image ROM data, valid 1 cycle after the address.
- palette_addr_out  out  8  palette ROM address (combinational copy of image_bits_in).
- palette_rgb_in  in  12  palette ROM data {R4,G4,B4}, valid 1 cycle after the address.
- pixel_out  out  12  output colour.
- opaque_out  out  1  1 when pixel_out is a visible sprite pixel.

Behaviour:
- Reset: every register is cleared.
  - pixel_out=BG_COLOR, opaque_out=0, image_addr_out=0.
  - anim_frame=0, tick_cnt=0, state=IDLE.
  - Latched dir/mirror = 0; all pipeline valid bits = 0.
  - Reset mid-line or mid-animation aborts everything; output returns to BG on the next edge.
- Shadow registers: dir, mirror and walking are sampled only on cycles with frame_start_in=1, so no mid-frame tearing. All address math uses the shadow values.
- Animation FSM, evaluated only when frame_start_in=1:
  - IDLE: anim_frame=0, tick_cnt=0. If walking_in=1, go to WALK.
  - WALK, walking_in=1: tick_cnt++. When tick_cnt reaches FRAME_TICKS-1, set tick_cnt=0 and anim_frame=(anim_frame+1) mod NUM_FRAMES (wraps NUM_FRAMES-1 -> 0).
  - WALK, walking_in=0: go to IDLE; anim_frame=0 and tick_cnt=0 take effect on the same edge.
  - A direction change while walking keeps anim_frame and tick_cnt.
- Hit test, done in 12-bit arithmetic so x_in near 2047 cannot wrap:
  - hit = hcount>=x && hcount<x+(WIDTH<<SCALE_LOG2) && vcount>=y && vcount<y+(HEIGHT<<SCALE_LOG2).
- Address:
  - col=(hcount-x)>>SCALE_LOG2; if mirror, col=WIDTH-1-col.
  - row=(vcount-y)>>SCALE_LOG2.
  - addr=((dir*NUM_FRAMES+anim_frame)*WIDTH*HEIGHT)+row*WIDTH+col.
  - When hit=0, the address is don't-care but must stay in range; drive 0.
- Pipeline: latency is exactly 3 cycles from hcount/vcount to pixel_out.
  - Edge k: image_addr_out and v1=hit are registered.
  - Edge k+1: the ROM registers its data; v2<=v1.
  - Edge k+2: t3<=(image_bits_in==TRANSPARENT_IDX); v3<=v2. palette_addr_out=image_bits_in drives the palette ROM.
  - Edge k+3: if v3 && !t3, pixel_out<=palette_rgb_in and opaque_out<=1; else pixel_out<=BG_COLOR and opaque_out<=0.
- Fully pipelined: a new pixel is accepted every cycle with no stalls. A frame_start_in that lands during an in-flight pixel does not alter that pixel's already-registered address.

Test Plan:
- Reset then idle: rst_in high 2 cycles with hcount inside the sprite. pixel_out=12'hFFF and opaque_out=0 through cycle 3 after release; image_addr_out=0 during reset.
- Latency/address:
  - Setup: x=100, y=50, dir=1, frame 0, SCALE_LOG2=0; at edge k set hcount=103, vcount=52.
  - Expect image_addr_out=1*4*1024+2*32+3=4163 at k+1. The ROM model returns index 5 and the palette maps 5->12'h3A7.
  - Expect pixel_out=12'h3A7 and opaque_out=1 exactly at k+3.
- Boundaries, x=100: hcount=99 and 132 give BG with opaque_out=0; hcount=100 and 131 give sprite pixels. With x=2040, hcount=2047 gives a hit and no wrap false-hit at hcount=5.
- Transparency: ROM returns TRANSPARENT_IDX (0) for an in-box pixel -> pixel_out=12'hFFF, opaque_out=0.
- Animation:
  - Walking=1, FRAME_TICKS=8: anim_frame steps 0->1 on the 8th frame_start pulse and wraps 3->0 on the 32nd.
  - Dropping walking mid-step gives anim_frame=0 at the next frame_start.
  - Changing dir mid-frame has no effect until frame_start.
- Mirror and scale:
  - mirror=1, col offset 0 -> address col field 31.
  - SCALE_LOG2=1: hcount=x+3 maps to col 1, and the box extends to x+63.
